// File: rtl/trigger_buffer_ctrl_pkg.sv
// Shared types and constants for the trigger buffer controller: state codes,
// trigger edge codes, default widths/depth and the sample-count clamp helper.
`ifndef __BITS_ADC
`define __BITS_ADC 12
`endif
`ifndef __RAM_SIZE_CH
`define __RAM_SIZE_CH 512
`endif

package trigger_buffer_ctrl_pkg;

  localparam int ADC_BITS  = `__BITS_ADC;
  localparam int RAM_DEPTH = `__RAM_SIZE_CH;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_FILL  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST_FILL = 3'd3,
    ST_REQUEST   = 3'd4,
    ST_READOUT   = 3'd5
  } state_e;

  // The sum is formed at 17 bits so pre+post cannot wrap before the clamp.
  function automatic logic [15:0] clamp_samples(input logic [15:0] pre,
                                                input logic [15:0] post,
                                                input int          depth);
    logic [16:0] sum;
    sum = {1'b0, pre} + {1'b0, post};
    if (sum > 17'(depth)) return 16'(depth);
    return sum[15:0];
  endfunction

endpackage

// File: rtl/trigger_buffer_ctrl_if.sv
// Host/RAM-side signal bundle of the trigger buffer controller.
// master = host/RAM side that drives commands and samples, slave = controller.
interface trigger_buffer_ctrl_if
  import trigger_buffer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_BITS
) ();

  // adc_ack is the RAM's write strobe: a sample is consumed on every cycle it
  // is high while wr_en is high; there is no back-pressure toward the RAM.
  logic                  start;
  logic                  abort;
  logic [15:0]           pre_trig;
  logic [15:0]           post_trig;
  logic [DATA_WIDTH-1:0] trig_level;
  logic                  trig_edge;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  adc_ack;
  logic                  data_eof;
  logic                  wr_en;
  logic                  rqst_buff;
  logic [15:0]           n_samples;
  logic                  busy;
  logic                  done;
  logic                  trig_auto;

  modport master (
    output start, abort, pre_trig, post_trig, trig_level, trig_edge,
    output adc_data, adc_ack, data_eof,
    input  wr_en, rqst_buff, n_samples, busy, done, trig_auto
  );

  modport slave (
    input  start, abort, pre_trig, post_trig, trig_level, trig_edge,
    input  adc_data, adc_ack, data_eof,
    output wr_en, rqst_buff, n_samples, busy, done, trig_auto
  );

endinterface

// File: rtl/trigger_buffer_ctrl_trigger_detector.sv
// Level-crossing detector: remembers the previous written sample and flags a
// crossing of the threshold on the current written sample.
module trigger_buffer_ctrl_trigger_detector
  import trigger_buffer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  track_i,
  input  logic                  eval_i,
  input  logic                  adc_ack_i,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  input  logic [DATA_WIDTH-1:0] level_i,
  input  logic                  edge_i,
  output logic                  trig_hit_o
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  prev_vld_q;
  logic                  rise;
  logic                  fall;

  always_comb begin
    rise       = (prev_q < level_i) && (adc_data_i >= level_i);
    fall       = (prev_q > level_i) && (adc_data_i <= level_i);
    trig_hit_o = eval_i && adc_ack_i && prev_vld_q &&
                 ((edge_i == TRIG_FALLING) ? fall : rise);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (track_i && adc_ack_i) begin
      prev_q     <= adc_data_i;
      prev_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/trigger_buffer_ctrl.sv
// Capture controller: arm, pre-trigger fill, trigger wait, post-trigger fill,
// buffer request and readout. Optional forced trigger under TRIG_AUTO_EN.
module trigger_buffer_ctrl
  import trigger_buffer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = ADC_BITS,
  parameter int BUFFER_DEPTH = RAM_DEPTH,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  trigger_buffer_ctrl_if.slave bus,
  output state_e               state_o
);

  localparam logic [15:0] PRE_MAX = 16'(BUFFER_DEPTH - 1);

  state_e                state_q, state_d;
  logic [15:0]           pre_q, pre_d, post_q, post_d;
  logic [15:0]           pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic [15:0]           n_q, n_d;
  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic                  edge_q, edge_d;
  logic                  wr_en_q, wr_en_d, rqst_q, rqst_d, done_q, done_d;
  logic                  auto_q, auto_d, eof_low_q, eof_low_d;
  logic                  start_go, trig_hit, force_hit, in_capture;

  assign in_capture = (state_q == ST_PRE_FILL) || (state_q == ST_WAIT_TRIG) ||
                      (state_q == ST_POST_FILL) || (state_q == ST_REQUEST);

  trigger_buffer_ctrl_trigger_detector #(.DATA_WIDTH(DATA_WIDTH)) u_det (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start_go),
    .track_i    ((state_q == ST_PRE_FILL) || (state_q == ST_WAIT_TRIG)),
    .eval_i     (state_q == ST_WAIT_TRIG),
    .adc_ack_i  (bus.adc_ack),
    .adc_data_i (bus.adc_data),
    .level_i    (level_q),
    .edge_i     (edge_q),
    .trig_hit_o (trig_hit)
  );

`ifdef TRIG_AUTO_EN
  localparam int TMR_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_done;

  assign tmr_done  = (tmr_q == TMR_W'(AUTO_TIMEOUT));
  assign force_hit = tmr_done && bus.adc_ack;

  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_WAIT_TRIG)) tmr_q <= '0;
    else if (!tmr_done)                   tmr_q <= tmr_q + TMR_W'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (AUTO_TIMEOUT != 0);
  assign force_hit      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    post_d     = post_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    n_d        = n_q;
    level_d    = level_q;
    edge_d     = edge_q;
    wr_en_d    = wr_en_q;
    rqst_d     = 1'b0;
    done_d     = 1'b0;
    auto_d     = auto_q;
    eof_low_d  = eof_low_q;
    start_go   = 1'b0;

    if (bus.abort && in_capture) begin
      state_d = ST_IDLE;
      wr_en_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            start_go   = 1'b1;
            pre_d      = (bus.pre_trig > PRE_MAX) ? PRE_MAX : bus.pre_trig;
            post_d     = bus.post_trig;
            level_d    = bus.trig_level;
            edge_d     = bus.trig_edge;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            auto_d     = 1'b0;
            wr_en_d    = 1'b1;
            state_d    = ST_PRE_FILL;
          end
        end
        ST_PRE_FILL: begin
          if (pre_cnt_q == pre_q) begin
            state_d = ST_WAIT_TRIG;
          end else if (bus.adc_ack) begin
            pre_cnt_d = pre_cnt_q + 16'd1;
            if (pre_cnt_q + 16'd1 == pre_q) state_d = ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_hit || force_hit) begin
            auto_d     = !trig_hit;
            post_cnt_d = 16'd1;
            // A window of 0 or 1 is the trigger sample alone: stop writing now.
            if (post_q <= 16'd1) begin
              wr_en_d = 1'b0;
              rqst_d  = 1'b1;
              n_d     = clamp_samples(pre_q, 16'd1, BUFFER_DEPTH);
              state_d = ST_REQUEST;
            end else begin
              state_d = ST_POST_FILL;
            end
          end
        end
        ST_POST_FILL: begin
          if (bus.adc_ack) begin
            post_cnt_d = post_cnt_q + 16'd1;
            if (post_cnt_q + 16'd1 >= post_q) begin
              wr_en_d = 1'b0;
              rqst_d  = 1'b1;
              n_d     = clamp_samples(pre_q, post_cnt_q + 16'd1, BUFFER_DEPTH);
              state_d = ST_REQUEST;
            end
          end
        end
        ST_REQUEST: begin
          eof_low_d = 1'b0;
          state_d   = ST_READOUT;
        end
        ST_READOUT: begin
          if (!bus.data_eof) begin
            eof_low_d = 1'b1;
          end else if (eof_low_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      post_q     <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      n_q        <= '0;
      level_q    <= '0;
      edge_q     <= TRIG_RISING;
      wr_en_q    <= 1'b0;
      rqst_q     <= 1'b0;
      done_q     <= 1'b0;
      auto_q     <= 1'b0;
      eof_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      n_q        <= n_d;
      level_q    <= level_d;
      edge_q     <= edge_d;
      wr_en_q    <= wr_en_d;
      rqst_q     <= rqst_d;
      done_q     <= done_d;
      auto_q     <= auto_d;
      eof_low_q  <= eof_low_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.rqst_buff = rqst_q;
  assign bus.n_samples = n_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.trig_auto = auto_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_trigger_buffer_ctrl.sv
// Directed bench for trigger_buffer_ctrl: a vector table of capture setups
// with hand-computed ack counts and sample counts, plus corner-case sequences.
module tb_trigger_buffer_ctrl;
  import trigger_buffer_ctrl_pkg::*;

  localparam int DW    = 12;
  localparam int DEPTH = 512;
  localparam int TMO   = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trigger_buffer_ctrl_if #(.DATA_WIDTH(DW)) bus ();
  state_e state;

  trigger_buffer_ctrl #(
    .DATA_WIDTH  (DW),
    .BUFFER_DEPTH(DEPTH),
    .AUTO_TIMEOUT(TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .state_o(state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0]   pre;
    logic [15:0]   post;
    logic [DW-1:0] level;
    logic          edge_sel;
    int            base;
    int            step;
    int            acks;
    logic [15:0]   exp_n;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.pre_trig   = '0;
    bus.post_trig  = '0;
    bus.trig_level = '0;
    bus.trig_edge  = 1'b0;
    bus.adc_data   = '0;
    bus.adc_ack    = 1'b0;
    bus.data_eof   = 1'b1;
  endtask

  task automatic arm(input logic [15:0] pre, input logic [15:0] post,
                     input logic [DW-1:0] level, input logic edge_sel);
    bus.pre_trig   = pre;
    bus.post_trig  = post;
    bus.trig_level = level;
    bus.trig_edge  = edge_sel;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // eof held high, then low (start is ignored meanwhile), then high -> done.
  task automatic finish_readout(input string tag);
    bus.data_eof = 1'b1;
    tick();
    tick();
    check({tag, "_ro_wait_done"}, 32'(bus.done), 0);
    check({tag, "_ro_wait_busy"}, 32'(bus.busy), 1);
    bus.data_eof = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    check({tag, "_ro_start_ignored"}, 32'(state), 32'(ST_READOUT));
    tick();
    bus.data_eof = 1'b1;
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 1);
    check({tag, "_busy_fall"}, 32'(bus.busy), 0);
    tick();
    check({tag, "_done_one_cycle"}, 32'(bus.done), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int viol;
    logic [15:0] exp_n;
    viol = 0;
    arm(v.pre, v.post, v.level, v.edge_sel);
    check({tag, "_wr_en_after_start"}, 32'(bus.wr_en), 1);
    exp_q.push_back(v.exp_n);
    for (int k = 0; k < v.acks; k++) begin
      if (bus.rqst_buff !== 1'b0 || bus.wr_en !== 1'b1) viol++;
      bus.adc_ack  = 1'b1;
      bus.adc_data = DW'(v.base + k * v.step);
      tick();
    end
    bus.adc_ack = 1'b0;
    check({tag, "_early_request"}, 32'(viol), 0);
    exp_n = exp_q.pop_front();
    check({tag, "_rqst"}, 32'(bus.rqst_buff), 1);
    check({tag, "_wr_en_drop"}, 32'(bus.wr_en), 0);
    check({tag, "_n_samples"}, 32'(bus.n_samples), 32'(exp_n));
    tick();
    check({tag, "_rqst_single"}, 32'(bus.rqst_buff), 0);
    check({tag, "_n_held"}, 32'(bus.n_samples), 32'(exp_n));
    finish_readout(tag);
  endtask

  // ---------------- test ----------------
  initial begin
    int cnt;
    vecs[0] = '{pre:4,   post:4,   level:128,  edge_sel:TRIG_RISING,  base:0,   step:40,  acks:8,    exp_n:8};
    vecs[1] = '{pre:1,   post:2,   level:100,  edge_sel:TRIG_FALLING, base:200, step:-50, acks:4,    exp_n:3};
    vecs[2] = '{pre:400, post:400, level:500,  edge_sel:TRIG_RISING,  base:0,   step:1,   acks:900,  exp_n:512};
    vecs[3] = '{pre:0,   post:1,   level:128,  edge_sel:TRIG_RISING,  base:0,   step:200, acks:2,    exp_n:1};
    vecs[4] = '{pre:2,   post:0,   level:10,   edge_sel:TRIG_RISING,  base:0,   step:5,   acks:3,    exp_n:3};
    vecs[5] = '{pre:600, post:3,   level:1000, edge_sel:TRIG_RISING,  base:0,   step:1,   acks:1003, exp_n:512};

    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_rqst", 32'(bus.rqst_buff), 0);
    check("rst_n_samples", 32'(bus.n_samples), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_trig_auto", 32'(bus.trig_auto), 0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start and abort together: abort wins
    bus.abort = 1'b1;
    arm(16'd4, 16'd4, 12'd128, TRIG_RISING);
    bus.abort = 1'b0;
    check("start_abort_busy", 32'(bus.busy), 0);
    check("start_abort_wr_en", 32'(bus.wr_en), 0);

    // abort in POST_FILL, then a normal second capture
    arm(16'd4, 16'd4, 12'd128, TRIG_RISING);
    for (int k = 0; k < 6; k++) begin
      bus.adc_ack  = 1'b1;
      bus.adc_data = DW'(k * 40);
      tick();
    end
    check("abort_pre_state", 32'(state), 32'(ST_POST_FILL));
    bus.adc_ack = 1'b0;
    bus.abort   = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_state", 32'(state), 32'(ST_IDLE));
    check("abort_wr_en", 32'(bus.wr_en), 0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.rqst_buff !== 1'b0) cnt++;
      tick();
    end
    check("abort_no_rqst", 32'(cnt), 0);
    run_vec(vecs[0], "restart");

    // flat 100,100,... on a falling threshold of 100 never triggers
    arm(16'd1, 16'd2, 12'd100, TRIG_FALLING);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      bus.adc_ack  = 1'b1;
      bus.adc_data = 12'd100;
      tick();
      if (bus.rqst_buff !== 1'b0) cnt++;
    end
    bus.adc_ack = 1'b0;
    check("flat_no_rqst", 32'(cnt), 0);
    check("flat_state", 32'(state), 32'(ST_WAIT_TRIG));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("flat_abort_idle", 32'(state), 32'(ST_IDLE));

    // constant input below threshold
    arm(16'd0, 16'd2, 12'd128, TRIG_RISING);
    bus.adc_ack  = 1'b1;
    bus.adc_data = 12'd50;
`ifdef TRIG_AUTO_EN
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.rqst_buff === 1'b1) begin
        cnt = 1;
        break;
      end
    end
    check("auto_rqst_seen", 32'(cnt), 1);
    check("auto_flag", 32'(bus.trig_auto), 1);
    check("auto_n_samples", 32'(bus.n_samples), 2);
`else
    cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (bus.rqst_buff !== 1'b0) cnt++;
    end
    check("noauto_no_rqst", 32'(cnt), 0);
    check("noauto_state", 32'(state), 32'(ST_WAIT_TRIG));
    check("noauto_flag", 32'(bus.trig_auto), 0);
    check("noauto_wr_en", 32'(bus.wr_en), 1);
`endif
    bus.adc_ack = 1'b0;

    // synchronous reset in the middle of a capture
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_wr_en", 32'(bus.wr_en), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_rqst", 32'(bus.rqst_buff), 0);
    check("midrst_n", 32'(bus.n_samples), 0);
    check("midrst_state", 32'(state), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
